// File: rtl/compare_set_pipe.sv
// Two-stage compare/set unit: S1 registers a - b with its carry and signed overflow,
// S2 registers the selected compare outcome and drives every output directly.
module compare_set_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             illegal
);

    typedef enum logic [2:0] {
        OP_SLT  = 3'b000,
        OP_SLTU = 3'b001,
        OP_SGE  = 3'b010,
        OP_SGEU = 3'b011,
        OP_SEQ  = 3'b100,
        OP_SNE  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    logic             s1_valid_q,   s1_valid_d;
    logic             s1_carry_q,   s1_carry_d;
    logic [WIDTH-1:0] s1_diff_q,    s1_diff_d;
    logic             s1_ovf_q,     s1_ovf_d;
    op_e              s1_op_q,      s1_op_d;
    logic             s1_illegal_q, s1_illegal_d;

    logic             s2_valid_q,   s2_valid_d;
    logic             s2_result_q,  s2_result_d;
    logic             s2_carry_q,   s2_carry_d;
    logic             s2_ovf_q,     s2_ovf_d;
    logic             s2_illegal_q, s2_illegal_d;

    logic             s2_advance;
    logic             s1_advance;
    logic             accept;
    logic             sub_carry;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_ovf;
    logic             slt_bit;
    logic             cmp_bit;

    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance && !flush;
    assign accept     = in_valid && in_ready;

    assign {sub_carry, sub_diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);

    // Signed less-than: the sign of the difference, corrected when the subtraction overflowed.
    assign slt_bit = s1_diff_q[WIDTH-1] ^ s1_ovf_q;

    always_comb begin
        cmp_bit = 1'b0;
        case (s1_op_q)
            OP_SLT:  cmp_bit = slt_bit;
            OP_SLTU: cmp_bit = !s1_carry_q;
            OP_SGE:  cmp_bit = !slt_bit;
            OP_SGEU: cmp_bit = s1_carry_q;
            OP_SEQ:  cmp_bit = (s1_diff_q == '0);
            OP_SNE:  cmp_bit = (s1_diff_q != '0);
            default: cmp_bit = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every _d is given its hold value first, so no path through this block infers a latch.
        s1_valid_d   = s1_valid_q;
        s1_carry_d   = s1_carry_q;
        s1_diff_d    = s1_diff_q;
        s1_ovf_d     = s1_ovf_q;
        s1_op_d      = s1_op_q;
        s1_illegal_d = s1_illegal_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_carry_d   = s2_carry_q;
        s2_ovf_d     = s2_ovf_q;
        s2_illegal_d = s2_illegal_q;

        if (s1_advance) s1_valid_d = accept;
        if (accept) begin
            s1_carry_d   = sub_carry;
            s1_diff_d    = sub_diff;
            s1_ovf_d     = sub_ovf;
            s1_op_d      = op_e'(op);
            s1_illegal_d = (op[2:1] == 2'b11);
        end

        if (s2_advance) s2_valid_d = s1_valid_q;
        if (s2_advance && s1_valid_q && !flush) begin
            s2_result_d  = cmp_bit;
            s2_carry_d   = s1_carry_q;
            s2_ovf_d     = s1_ovf_q;
            s2_illegal_d = s1_illegal_q;
        end

        // Flush overrides any advance happening in the same cycle.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: the datapath registers are reset as well, because S2 drives the outputs and they must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_carry_q   <= 1'b0;
            s1_diff_q    <= '0;
            s1_ovf_q     <= 1'b0;
            s1_op_q      <= OP_SLT;
            s1_illegal_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 1'b0;
            s2_carry_q   <= 1'b0;
            s2_ovf_q     <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q   <= s1_valid_d;
            s1_carry_q   <= s1_carry_d;
            s1_diff_q    <= s1_diff_d;
            s1_ovf_q     <= s1_ovf_d;
            s1_op_q      <= s1_op_d;
            s1_illegal_q <= s1_illegal_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_carry_q   <= s2_carry_d;
            s2_ovf_q     <= s2_ovf_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = {{(WIDTH-1){1'b0}}, s2_result_q};
    assign carryout  = s2_carry_q;
    assign overflow  = s2_ovf_q;
    assign illegal   = s2_illegal_q;

endmodule

// File: tb/tb_compare_set_pipe.sv
// Bench for compare_set_pipe: a 32-bit and an 8-bit instance share handshake controls,
// checked by directed tables, multi-cycle sequences and a randomized scoreboard.
module tb_compare_set_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  op;
    logic        flush;
    logic        out_ready;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic        in_ready32, out_valid32, carry32, ovf32, ill32;
    logic [31:0] res32;
    logic        in_ready8, out_valid8, carry8, ovf8, ill8;
    logic [7:0]  res8;

    always #5 clk = ~clk;

    compare_set_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a32), .b(b32), .op(op), .flush(flush), .out_valid(out_valid32),
        .out_ready(out_ready), .result(res32), .carryout(carry32),
        .overflow(ovf32), .illegal(ill32)
    );

    compare_set_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op), .flush(flush), .out_valid(out_valid8),
        .out_ready(out_ready), .result(res8), .carryout(carry8),
        .overflow(ovf8), .illegal(ill8)
    );

    typedef struct packed {
        logic res;
        logic carry;
        logic ovf;
        logic ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a32, b32;
        logic [7:0]  a8, b8;
        exp_t        e32, e8;
    } vec_t;

    typedef struct {
        logic [31:0] r32;
        logic        c32, o32, i32;
        logic        v8;
        logic [7:0]  r8;
        logic        c8, o8, i8;
        int          cyc;
    } obs_t;

    typedef struct {
        exp_t e32;
        exp_t e8;
    } pend_t;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    logic   mon_en   = 1'b0;
    obs_t   mon_q[$];
    pend_t  mq[$];
    vec_t   vecs[12];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && out_valid32 && out_ready) begin
            obs_t o;
            o.r32 = res32; o.c32 = carry32; o.o32 = ovf32; o.i32 = ill32;
            o.v8  = out_valid8;
            o.r8  = res8;  o.c8  = carry8;  o.o8  = ovf8;  o.i8  = ill8;
            o.cyc = cyc;
            mon_q.push_back(o);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: compare mathematical signed/unsigned values of the operands at width w.
    function automatic exp_t model(input int w, input longint unsigned x, input longint unsigned y,
                                   input logic [2:0] o);
        longint unsigned mask, ux, uy;
        longint          sx, sy, half, d;
        exp_t            e;
        mask = (64'd1 << w) - 64'd1;
        ux   = x & mask;
        uy   = y & mask;
        half = longint'(64'd1 << (w - 1));
        sx   = longint'(ux);
        sy   = longint'(uy);
        if (ux[w-1]) sx = sx - 2 * half;
        if (uy[w-1]) sy = sy - 2 * half;
        d       = sx - sy;
        e.carry = (ux >= uy);
        e.ovf   = (d >= half) || (d < -half);
        e.ill   = (o[2:1] == 2'b11);
        case (o)
            3'd0:    e.res = (sx < sy);
            3'd1:    e.res = (ux < uy);
            3'd2:    e.res = (sx >= sy);
            3'd3:    e.res = (ux >= uy);
            3'd4:    e.res = (ux == uy);
            3'd5:    e.res = (ux != uy);
            default: e.res = 1'b0;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input string n, input logic [2:0] o, input logic [31:0] x32,
                                input logic [31:0] y32, input logic [7:0] x8, input logic [7:0] y8,
                                input logic [3:0] e32, input logic [3:0] e8);
        vec_t v;
        v.name = n; v.op = o; v.a32 = x32; v.b32 = y32; v.a8 = x8; v.b8 = y8;
        v.e32 = exp_t'(e32); v.e8 = exp_t'(e8);
        return v;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'h7F;
            3:       return 8'hFF;
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] o, input logic [31:0] x32, input logic [31:0] y32,
                           input logic [7:0] x8, input logic [7:0] y8);
        in_valid = 1'b1; op = o; a32 = x32; b32 = y32; a8 = x8; b8 = y8;
    endtask

    task automatic cmp_obs(input string n, input int idx, input exp_t e32, input exp_t e8);
        check({n, "_present"}, 64'(mon_q.size() > idx), 64'd1);
        if (mon_q.size() > idx) begin
            check({n, "_w32"}, {mon_q[idx].r32, mon_q[idx].c32, mon_q[idx].o32, mon_q[idx].i32},
                  {31'b0, e32.res, e32.carry, e32.ovf, e32.ill});
            check({n, "_w8"}, {mon_q[idx].v8, mon_q[idx].r8, mon_q[idx].c8, mon_q[idx].o8, mon_q[idx].i8},
                  {1'b1, 7'b0, e8.res, e8.carry, e8.ovf, e8.ill});
        end
    endtask

    task automatic rand_cycle(input logic iv, input logic [2:0] o, input logic [31:0] x32,
                              input logic [31:0] y32, input logic [7:0] x8, input logic [7:0] y8,
                              input logic fl, input logic ordy);
        logic  exp_rdy;
        pend_t p;
        in_valid = iv; op = o; a32 = x32; b32 = y32; a8 = x8; b8 = y8;
        flush = fl; out_ready = ordy;
        #1;
        exp_rdy = !fl && (mq.size() < 2 || ordy);
        check("rand_in_ready32", 64'(in_ready32), 64'(exp_rdy));
        check("rand_in_ready8", 64'(in_ready8), 64'(exp_rdy));
        if (mq.size() == 0) begin
            check("rand_idle_valid", {out_valid32, out_valid8}, 64'd0);
        end else if (out_valid32) begin
            check("rand_out_w32", {res32, carry32, ovf32, ill32},
                  {31'b0, mq[0].e32.res, mq[0].e32.carry, mq[0].e32.ovf, mq[0].e32.ill});
            check("rand_out_w8", {out_valid8, res8, carry8, ovf8, ill8},
                  {1'b1, 7'b0, mq[0].e8.res, mq[0].e8.carry, mq[0].e8.ovf, mq[0].e8.ill});
            if (ordy) void'(mq.pop_front());
        end
        if (fl) begin
            mq.delete();
        end else if (iv && exp_rdy) begin
            p.e32 = model(32, 64'(x32), 64'(y32), o);
            p.e8  = model(8, 64'(x8), 64'(y8), o);
            mq.push_back(p);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int   c_first;
        exp_t ea32, ea8;

        // result/flags pack: {res, carry, ovf, ill}
        vecs[0]  = mk("slt_min_1",   3'b000, 32'h8000_0000, 32'h0000_0001, 8'h80, 8'h01, 4'b1110, 4'b1110);
        vecs[1]  = mk("sltu_1_m1",   3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 8'h01, 8'hFF, 4'b1000, 4'b1000);
        vecs[2]  = mk("slt_1_m1",    3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 8'h01, 8'hFF, 4'b0000, 4'b0000);
        vecs[3]  = mk("seq_5_5",     3'b100, 32'h5,         32'h5,         8'h05, 8'h05, 4'b1100, 4'b1100);
        vecs[4]  = mk("sne_5_5",     3'b101, 32'h5,         32'h5,         8'h05, 8'h05, 4'b0100, 4'b0100);
        vecs[5]  = mk("sge_m1_0",    3'b010, 32'hFFFF_FFFF, 32'h0,         8'hFF, 8'h00, 4'b0100, 4'b0100);
        vecs[6]  = mk("sgeu_m1_0",   3'b011, 32'hFFFF_FFFF, 32'h0,         8'hFF, 8'h00, 4'b1100, 4'b1100);
        vecs[7]  = mk("rsv6",        3'b110, 32'h3,         32'h7,         8'h03, 8'h07, 4'b0001, 4'b0001);
        vecs[8]  = mk("rsv7",        3'b111, 32'h7,         32'h3,         8'h07, 8'h03, 4'b0101, 4'b0101);
        vecs[9]  = mk("sge_max_min", 3'b010, 32'h7FFF_FFFF, 32'h8000_0000, 8'h7F, 8'h80, 4'b1010, 4'b1010);
        vecs[10] = mk("sltu_0_0",    3'b001, 32'h0,         32'h0,         8'h00, 8'h00, 4'b0100, 4'b0100);
        vecs[11] = mk("sne_adj",     3'b101, 32'h1234_5678, 32'h1234_5679, 8'h78, 8'h79, 4'b1000, 4'b1000);

        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; flush = 1'b0; out_ready = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        #2;
        check("reset_out32", {out_valid32, res32, carry32, ovf32, ill32}, 64'd0);
        check("reset_out8", {out_valid8, res8, carry8, ovf8, ill8}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", {in_ready32, in_ready8}, 64'b11);

        // Directed table streamed back to back with out_ready held high.
        mon_q.delete();
        mon_en = 1'b1; out_ready = 1'b1;
        c_first = cyc;
        foreach (vecs[i]) begin
            present(vecs[i].op, vecs[i].a32, vecs[i].b32, vecs[i].a8, vecs[i].b8);
            #1;
            check({"stream_in_ready_", vecs[i].name}, {in_ready32, in_ready8}, 64'b11);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("stream_count", 64'(mon_q.size()), 64'd12);
        foreach (vecs[i]) cmp_obs(vecs[i].name, i, vecs[i].e32, vecs[i].e8);
        if (mon_q.size() > 0) check("stream_latency", 64'(mon_q[0].cyc - c_first), 64'd2);
        for (int i = 1; i < mon_q.size(); i++)
            check("stream_back_to_back", 64'(mon_q[i].cyc - mon_q[i-1].cyc), 64'd1);

        // Stall: two operations held for five cycles, then released with a new input.
        mon_q.delete();
        out_ready = 1'b0;
        present(3'b001, 32'h1, 32'hFFFF_FFFF, 8'h01, 8'hFF);
        step();
        present(3'b100, 32'h5, 32'h5, 8'h05, 8'h05);
        step();
        in_valid = 1'b0;
        ea32 = model(32, 64'h1, 64'hFFFF_FFFF, 3'b001);
        ea8  = model(8, 64'h01, 64'hFF, 3'b001);
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", {in_ready32, in_ready8}, 64'b00);
            check("stall_out_valid", {out_valid32, out_valid8}, 64'b11);
            check("stall_hold_w32", {res32, carry32, ovf32, ill32},
                  {31'b0, ea32.res, ea32.carry, ea32.ovf, ea32.ill});
            check("stall_hold_w8", {res8, carry8, ovf8, ill8},
                  {7'b0, ea8.res, ea8.carry, ea8.ovf, ea8.ill});
            step();
        end
        out_ready = 1'b1;
        present(3'b010, 32'h7FFF_FFFF, 32'h8000_0000, 8'h7F, 8'h80);
        #1;
        check("release_in_ready", {in_ready32, in_ready8}, 64'b11);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("release_count", 64'(mon_q.size()), 64'd3);
        cmp_obs("release_a", 0, ea32, ea8);
        cmp_obs("release_b", 1, model(32, 64'h5, 64'h5, 3'b100), model(8, 64'h5, 64'h5, 3'b100));
        cmp_obs("release_c", 2, model(32, 64'h7FFF_FFFF, 64'h8000_0000, 3'b010),
                model(8, 64'h7F, 64'h80, 3'b010));

        // Flush with both stages full and a simultaneous input.
        mon_q.delete();
        out_ready = 1'b0;
        present(3'b000, 32'h8000_0000, 32'h1, 8'h80, 8'h01);
        step();
        present(3'b101, 32'h5, 32'h5, 8'h05, 8'h05);
        step();
        present(3'b100, 32'h0, 32'h0, 8'h00, 8'h00);
        flush = 1'b1;
        #1;
        check("flush_in_ready", {in_ready32, in_ready8}, 64'b00);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {out_valid32, out_valid8}, 64'b00);
        out_ready = 1'b1;
        present(3'b011, 32'h5, 32'h3, 8'h05, 8'h03);
        #1;
        check("after_flush_in_ready", {in_ready32, in_ready8}, 64'b11);
        step();
        in_valid = 1'b0;
        check("after_flush_lat1", {out_valid32, out_valid8}, 64'b00);
        step();
        check("after_flush_lat2", {out_valid32, out_valid8}, 64'b11);
        repeat (3) step();
        check("flush_count", 64'(mon_q.size()), 64'd1);
        cmp_obs("after_flush", 0, model(32, 64'h5, 64'h3, 3'b011), model(8, 64'h5, 64'h3, 3'b011));

        // Asynchronous reset between edges with both stages full.
        mon_q.delete();
        out_ready = 1'b0;
        present(3'b001, 32'h2, 32'h9, 8'h02, 8'h09);
        step();
        present(3'b000, 32'hFFFF_FFF0, 32'h4, 8'hF0, 8'h04);
        step();
        in_valid = 1'b0;
        check("prereset_full", {out_valid32, out_valid8}, 64'b11);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_w32", {out_valid32, res32, carry32, ovf32, ill32}, 64'd0);
        check("async_reset_w8", {out_valid8, res8, carry8, ovf8, ill8}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("reset_release_in_ready", {in_ready32, in_ready8}, 64'b11);
        repeat (4) step();
        check("reset_discards", 64'(mon_q.size()), 64'd0);
        mon_en = 1'b0;

        // Randomized traffic against the queue-based reference.
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] x32, y32;
            logic [7:0]  x8, y8;
            x32 = pick32(); y32 = pick32(); x8 = pick8(); y8 = pick8();
            if ($urandom_range(0, 4) == 0) y32 = x32;
            if ($urandom_range(0, 4) == 0) y8 = x8;
            rand_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), x32, y32, x8, y8,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 8 && mq.size() > 0; k++)
            rand_cycle(1'b0, 3'b000, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 1'b1);
        check("rand_drain", 64'(mq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
